// File: rtl/my_uart.sv
// Loopback UART: TX FIFO -> serial transmitter -> 2-flop synchronizer -> receiver -> RX FIFO.
// 8 data bits + even parity per frame, oversampled at ClkTicks baud ticks per bit.
module my_uart_fifo #(
  parameter int W        = 8,
  parameter int AddrBits = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int Depth = 2 ** AddrBits;
  localparam logic [AddrBits:0] CntFull = (AddrBits + 1)'(Depth);

  logic [W-1:0]        r_mem [Depth];
  logic [AddrBits-1:0] r_wp;
  logic [AddrBits-1:0] r_rp;
  logic [AddrBits:0]   r_cnt;
  logic                w_push_ok;
  logic                w_pop_ok;

  assign o_full    = (r_cnt == CntFull);
  assign o_empty   = (r_cnt == '0);
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;
  // First-word fall-through head; reads as zero while empty.
  assign o_data    = o_empty ? '0 : r_mem[r_rp];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push_ok) r_wp <= r_wp + 1'b1;
      if (w_pop_ok)  r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AddrBits + 1)'(w_push_ok) - (AddrBits + 1)'(w_pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wp] <= i_data;
  end
endmodule

module my_uart #(
  parameter int DataBits = 9,
  parameter int ClkTicks = 16,
  parameter int AddrBits = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [11:0]                   FinalValue,
  input  logic [DataBits-2:0]           w_data,
  input  logic                          wr_en,
  output logic                          T_full,
  output logic [DataBits-2:0]           r_data,
  input  logic                          rd_en,
  output logic                          R_empty,
  output logic                          error_check,
  output logic [$clog2(ClkTicks)-1:0]   c_T,
  output logic [$clog2(ClkTicks)-1:0]   c_R,
  output logic [$clog2(DataBits)-1:0]   n_T,
  output logic [$clog2(DataBits)-1:0]   n_R
);
  localparam int DW = DataBits - 1;
  localparam int CW = $clog2(ClkTicks);
  localparam int NW = $clog2(DataBits);
  localparam logic [CW-1:0] CLast = CW'(ClkTicks - 1);
  localparam logic [CW-1:0] CHalf = CW'(ClkTicks / 2 - 1);
  localparam logic [NW-1:0] NLast = NW'(DataBits - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [11:0]         r_tcnt;
  logic                w_tick;
  logic [DW-1:0]       w_t_head;
  logic                w_t_empty;
  logic                w_t_pop;
  logic                w_t_end;
  logic [DataBits-1:0] w_t_load;
  state_t              r_tstate;
  logic [CW-1:0]       r_ct;
  logic [NW-1:0]       r_nt;
  logic [DataBits-1:0] r_tshift;
  logic                r_tx;
  logic                w_line;
  logic [1:0]          r_sync;
  logic                w_rx;
  state_t              r_rstate;
  logic [CW-1:0]       r_cr;
  logic [NW-1:0]       r_nr;
  logic [DataBits-1:0] r_rshift;
  logic                r_err;
  logic                w_r_push;
  logic                w_r_full;

  assign w_tick = (r_tcnt == FinalValue);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_tcnt <= '0;
    else          r_tcnt <= w_tick ? '0 : r_tcnt + 12'd1;
  end

  my_uart_fifo #(.W(DW), .AddrBits(AddrBits)) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (wr_en),
    .i_data  (w_data),
    .i_pop   (w_t_pop),
    .o_data  (w_t_head),
    .o_full  (T_full),
    .o_empty (w_t_empty)
  );

  // Shifter holds {even parity, data}; popping from STOP chains frames with no idle gap.
  assign w_t_load = {^w_t_head, w_t_head};
  assign w_t_end  = w_tick && (r_ct == CLast);
  assign w_t_pop  = !w_t_empty && ((r_tstate == IDLE) || (r_tstate == STOP && w_t_end));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tstate <= IDLE;
      r_ct     <= '0;
      r_nt     <= '0;
      r_tshift <= '0;
      r_tx     <= 1'b1;
    end else begin
      case (r_tstate)
        IDLE: if (w_t_pop) begin
          r_tshift <= w_t_load;
          r_tx     <= 1'b0;
          r_ct     <= '0;
          r_tstate <= START;
        end
        START: if (w_tick) begin
          if (r_ct == CLast) begin
            r_ct     <= '0;
            r_nt     <= '0;
            r_tx     <= r_tshift[0];
            r_tshift <= {1'b0, r_tshift[DataBits-1:1]};
            r_tstate <= DATA;
          end else r_ct <= r_ct + 1'b1;
        end
        DATA: if (w_tick) begin
          if (r_ct == CLast) begin
            r_ct <= '0;
            if (r_nt == NLast) begin
              r_nt     <= '0;
              r_tx     <= 1'b1;
              r_tstate <= STOP;
            end else begin
              r_nt     <= r_nt + 1'b1;
              r_tx     <= r_tshift[0];
              r_tshift <= {1'b0, r_tshift[DataBits-1:1]};
            end
          end else r_ct <= r_ct + 1'b1;
        end
        STOP: if (w_tick) begin
          if (r_ct == CLast) begin
            r_ct <= '0;
            if (w_t_pop) begin
              r_tshift <= w_t_load;
              r_tx     <= 1'b0;
              r_tstate <= START;
            end else r_tstate <= IDLE;
          end else r_ct <= r_ct + 1'b1;
        end
        default: r_tstate <= IDLE;
      endcase
    end
  end

  assign w_line = r_tx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], w_line};
  end
  assign w_rx = r_sync[1];

  // Samples land mid-bit: START waits half a bit, every later sample is a full bit apart.
  assign w_r_push = (r_rstate == STOP) && w_tick && (r_cr == CLast) && !w_r_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rstate <= IDLE;
      r_cr     <= '0;
      r_nr     <= '0;
      r_rshift <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_rstate)
        IDLE: if (!w_rx) begin
          r_cr     <= '0;
          r_rstate <= START;
        end
        START: if (w_tick) begin
          if (r_cr == CHalf) begin
            r_cr     <= '0;
            r_nr     <= '0;
            r_rstate <= w_rx ? IDLE : DATA;
          end else r_cr <= r_cr + 1'b1;
        end
        DATA: if (w_tick) begin
          if (r_cr == CLast) begin
            r_cr     <= '0;
            r_rshift <= {w_rx, r_rshift[DataBits-1:1]};
            if (r_nr == NLast) begin
              r_nr     <= '0;
              r_rstate <= STOP;
            end else r_nr <= r_nr + 1'b1;
          end else r_cr <= r_cr + 1'b1;
        end
        STOP: if (w_tick) begin
          if (r_cr == CLast) begin
            r_cr     <= '0;
            r_err    <= (^r_rshift) | ~w_rx;
            r_rstate <= IDLE;
          end else r_cr <= r_cr + 1'b1;
        end
        default: r_rstate <= IDLE;
      endcase
    end
  end

  my_uart_fifo #(.W(DW), .AddrBits(AddrBits)) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_r_push),
    .i_data  (r_rshift[DW-1:0]),
    .i_pop   (rd_en),
    .o_data  (r_data),
    .o_full  (w_r_full),
    .o_empty (R_empty)
  );

  assign error_check = r_err;
  assign c_T = r_ct;
  assign n_T = r_nt;
  assign c_R = r_cr;
  assign n_R = r_nr;
endmodule

// File: tb/tb_my_uart.sv
// Scoreboard bench for my_uart: writes push expected bytes, a monitor pops and checks RX output.
module tb_my_uart;
  logic        clk;
  logic        reset_n;
  logic [11:0] FinalValue;
  logic [7:0]  w_data;
  logic        wr_en;
  logic        T_full;
  logic [7:0]  r_data;
  logic        rd_en;
  logic        R_empty;
  logic        error_check;
  logic [3:0]  c_T, c_R, n_T, n_R;

  my_uart dut (
    .clk(clk), .reset_n(reset_n), .FinalValue(FinalValue),
    .w_data(w_data), .wr_en(wr_en), .T_full(T_full),
    .r_data(r_data), .rd_en(rd_en), .R_empty(R_empty),
    .error_check(error_check), .c_T(c_T), .c_R(c_R), .n_T(n_T), .n_R(n_R)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       e;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 0;
  int   dummy_req  = 0;
  int   dummy_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
  endtask

  task automatic wr(input logic [7:0] d, input bit expect_rx, input bit perr);
    @(negedge clk);
    w_data = d;
    wr_en  = 1'b1;
    if (expect_rx) q.push_back('{d: d, e: perr});
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    repeat (4) @(negedge clk);
    chk("drain_queue", 32'(q.size()), 32'd0);
    chk("drain_R_empty", 32'(R_empty), 32'd1);
  endtask

  // Monitor: every byte the DUT presents is checked against the head of the queue.
  initial begin
    exp_t e;
    rd_en = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && reset_n && !R_empty) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL rx_unexpected: got byte 0x%0h, required no byte", r_data);
        end else begin
          e = q.pop_front();
          chk("rx_data", 32'(r_data), 32'(e.d));
          chk("rx_error_check", 32'(error_check), 32'(e.e));
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
      end else if (dummy_req != dummy_done) begin
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        dummy_done++;
      end
    end
  end

  initial begin
    #(600000 * 10);
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq [7];
    int lat;
    bit found;
    seq = '{8'h82, 8'h11, 8'h00, 8'h70, 8'hD4, 8'h07, 8'h1B};
    reset_n    = 1'b0;
    wr_en      = 1'b0;
    w_data     = 8'h00;
    FinalValue = 12'd2;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_T_full", 32'(T_full), 32'd0);
    chk("rst_R_empty", 32'(R_empty), 32'd1);
    chk("rst_error_check", 32'(error_check), 32'd0);
    chk("rst_r_data", 32'(r_data), 32'd0);
    chk("rst_c_T", 32'(c_T), 32'd0);
    chk("rst_c_R", 32'(c_R), 32'd0);
    chk("rst_n_T", 32'(n_T), 32'd0);
    chk("rst_n_R", 32'(n_R), 32'd0);

    dummy_req++;
    for (int i = 0; i < 20 && dummy_done != dummy_req; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("empty_rd_R_empty", 32'(R_empty), 32'd1);
    chk("empty_rd_r_data", 32'(r_data), 32'd0);
    chk("empty_rd_T_full", 32'(T_full), 32'd0);

    mon_en = 1'b1;
    wr(8'h1D, 1'b1, 1'b0);
    lat = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!R_empty) break;
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat >= 480 && lat <= 540) n_pass++;
    else $display("FAIL frame_latency: got %0d clks, required 480..540", lat);
    wait_drain(1500);

    foreach (seq[k]) begin
      wr(seq[k], 1'b1, 1'b0);
      wait_drain(1500);
    end

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      w_data = 8'h30 + 8'(i);
      wr_en  = 1'b1;
      q.push_back('{d: 8'h30 + 8'(i), e: 1'b0});
    end
    @(negedge clk);
    chk("burst_T_full_17", 32'(T_full), 32'd1);
    w_data = 8'hEE;
    @(negedge clk);
    wr_en = 1'b0;
    chk("burst_T_full_18", 32'(T_full), 32'd1);
    wait_drain(12000);
    repeat (1200) @(negedge clk);
    chk("burst_no_extra", 32'(R_empty), 32'd1);

    wr(8'h55, 1'b0, 1'b0);
    repeat (200) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_R_empty", 32'(R_empty), 32'd1);
    chk("midrst_n_T", 32'(n_T), 32'd0);
    chk("midrst_line", 32'(dut.r_tx), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (1200) @(negedge clk);
    chk("midrst_no_byte", 32'(R_empty), 32'd0 + 32'd1);
    chk("midrst_line_idle", 32'(dut.r_tx), 32'd1);
    chk("midrst_c_T", 32'(c_T), 32'd0);

    wr(8'h01, 1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (n_T == 4'd8) begin
        found = 1'b1;
        break;
      end
    end
    chk("parity_window_open", 32'(found), 32'd1);
    force dut.w_line = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_T != 4'd8) begin
        found = 1'b1;
        break;
      end
    end
    release dut.w_line;
    chk("parity_window_close", 32'(found), 32'd1);
    wait_drain(1500);
    chk("parity_err_held", 32'(error_check), 32'd1);

    wr(8'h01, 1'b1, 1'b0);
    wait_drain(1500);
    chk("clean_err_cleared", 32'(error_check), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
